// File: rtl/nibble_serial_comparator_if.sv
// ----------------------------------------------------------------------------
// nibble_serial_comparator_if: operand/result handshake bundle for the comparator
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface nibble_serial_comparator_if #(
  parameter int WIDTH = 16
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int NUW     = $clog2(NIBBLES) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [NUW-1:0]   nibbles_used;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, gt, eq, lt, nibbles_used
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, gt, eq, lt, nibbles_used
  );
endinterface

`default_nettype wire

// File: rtl/nibble_serial_comparator.sv
// ----------------------------------------------------------------------------
// nibble_serial_comparator: MSB-first, one nibble per clock unsigned comparator
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nibble_serial_comparator #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  nibble_serial_comparator_if.slave  bus
);
  localparam int            NIBBLES    = WIDTH / 4;
  localparam int            CW         = $clog2(NIBBLES) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(NIBBLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             casc_g;
  logic             casc_e;
  logic             casc_l;
  logic [CW-1:0]    count;
  logic             out_valid_r;
  logic             gt_r;
  logic             eq_r;
  logic             lt_r;
  logic [CW-1:0]    nibbles_used_r;

  logic [3:0]       top_a;
  logic [3:0]       top_b;
  logic             next_g;
  logic             next_e;
  logic             next_l;
  logic [CW-1:0]    count_inc;
  logic             finish;

  assign top_a = sh_a[WIDTH-1 -: 4];
  assign top_b = sh_b[WIDTH-1 -: 4];

  // Cascade rule: once a higher nibble has decided, lower nibbles cannot change it.
  always_comb begin
    next_g = casc_g;
    next_e = casc_e;
    next_l = casc_l;
    if (casc_e) begin
      next_g = (top_a > top_b);
      next_e = (top_a == top_b);
      next_l = (top_a < top_b);
    end
  end

  assign count_inc = count + 1'b1;
  assign finish    = (count_inc == LAST_COUNT) || (EARLY_EXIT && !next_e);

  assign bus.in_ready     = (state == IDLE) && !rst;
  assign bus.out_valid    = out_valid_r;
  assign bus.gt           = gt_r;
  assign bus.eq           = eq_r;
  assign bus.lt           = lt_r;
  assign bus.nibbles_used = nibbles_used_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      sh_a           <= '0;
      sh_b           <= '0;
      casc_g         <= 1'b0;
      casc_e         <= 1'b1;
      casc_l         <= 1'b0;
      count          <= '0;
      out_valid_r    <= 1'b0;
      gt_r           <= 1'b0;
      eq_r           <= 1'b0;
      lt_r           <= 1'b0;
      nibbles_used_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sh_a   <= bus.a;
            sh_b   <= bus.b;
            casc_g <= 1'b0;
            casc_e <= 1'b1;
            casc_l <= 1'b0;
            count  <= '0;
            state  <= COMPARE;
          end
        end
        COMPARE: begin
          casc_g <= next_g;
          casc_e <= next_e;
          casc_l <= next_l;
          sh_a   <= sh_a << 4;
          sh_b   <= sh_b << 4;
          count  <= count_inc;
          if (finish) begin
            gt_r           <= next_g;
            eq_r           <= next_e;
            lt_r           <= next_l;
            nibbles_used_r <= count_inc;
            out_valid_r    <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          // Result fields stay put after the handshake until the next result.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_comparator.sv
// Scoreboard bench: three comparator builds (16b early-exit, 16b full, 4b).
`timescale 1ns/1ps
`default_nettype none

module tb_nibble_serial_comparator;
  typedef struct {
    int id;
    int g;
    int e;
    int l;
    int nu;
    int lat;
    int acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   last_acc4 = 0;
  exp_t q[$];
  exp_t cur[3];
  bit   seen[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_comparator_if #(.WIDTH(16)) bus_e ();
  nibble_serial_comparator_if #(.WIDTH(16)) bus_f ();
  nibble_serial_comparator_if #(.WIDTH(4))  bus_4 ();

  nibble_serial_comparator #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut_e (.clk(clk), .rst(rst), .bus(bus_e.slave));
  nibble_serial_comparator #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut_f (.clk(clk), .rst(rst), .bus(bus_f.slave));
  nibble_serial_comparator #(.WIDTH(4),  .EARLY_EXIT(1'b1)) dut_4 (.clk(clk), .rst(rst), .bus(bus_4.slave));

  logic ov[3];
  logic ordy[3];
  logic og[3];
  logic oe[3];
  logic ol[3];
  int   onu[3];

  assign ov[0] = bus_e.out_valid;  assign ov[1] = bus_f.out_valid;  assign ov[2] = bus_4.out_valid;
  assign ordy[0] = bus_e.out_ready; assign ordy[1] = bus_f.out_ready; assign ordy[2] = bus_4.out_ready;
  assign og[0] = bus_e.gt;  assign og[1] = bus_f.gt;  assign og[2] = bus_4.gt;
  assign oe[0] = bus_e.eq;  assign oe[1] = bus_f.eq;  assign oe[2] = bus_4.eq;
  assign ol[0] = bus_e.lt;  assign ol[1] = bus_f.lt;  assign ol[2] = bus_4.lt;
  assign onu[0] = int'(bus_e.nibbles_used);
  assign onu[1] = int'(bus_f.nibbles_used);
  assign onu[2] = int'(bus_4.nibbles_used);

  function automatic void chk(input string nm, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  // Monitor: pops the expected result when a DUT raises out_valid, then checks hold.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        seen[d] = 1'b0;
      end else if (ov[d]) begin
        if (!seen[d]) begin
          if (q.size() == 0 || q[0].id != d) begin
            compared++;
            mismatched++;
            $display("FAIL dut%0d_unexpected_result: got out_valid=1 gt=%0d eq=%0d lt=%0d, expected no result",
                     d, og[d], oe[d], ol[d]);
            cur[d] = '{d, int'(og[d]), int'(oe[d]), int'(ol[d]), onu[d], 0, cyc};
          end else begin
            cur[d] = q.pop_front();
            chk($sformatf("dut%0d_gt", d), int'(og[d]), cur[d].g);
            chk($sformatf("dut%0d_eq", d), int'(oe[d]), cur[d].e);
            chk($sformatf("dut%0d_lt", d), int'(ol[d]), cur[d].l);
            chk($sformatf("dut%0d_nibbles_used", d), onu[d], cur[d].nu);
            chk($sformatf("dut%0d_latency", d), cyc - cur[d].acc, cur[d].lat);
          end
          seen[d] = 1'b1;
        end else begin
          chk($sformatf("dut%0d_hold_flags", d), {29'd0, og[d], oe[d], ol[d]},
              cur[d].g * 4 + cur[d].e * 2 + cur[d].l);
          chk($sformatf("dut%0d_hold_nibbles_used", d), onu[d], cur[d].nu);
        end
        if (ordy[d]) seen[d] = 1'b0;
      end
    end
  end

  task automatic set_in(input int d, input logic v, input logic [15:0] va, input logic [15:0] vb);
    case (d)
      0: begin bus_e.in_valid = v; bus_e.a = va; bus_e.b = vb; end
      1: begin bus_f.in_valid = v; bus_f.a = va; bus_f.b = vb; end
      default: begin bus_4.in_valid = v; bus_4.a = va[3:0]; bus_4.b = vb[3:0]; end
    endcase
  endtask

  function automatic logic get_rdy(input int d);
    case (d)
      0: return bus_e.in_ready;
      1: return bus_f.in_ready;
      default: return bus_4.in_ready;
    endcase
  endfunction

  // Offer a pair, wait (bounded) for acceptance, queue the expected response.
  task automatic send(input int d, input logic [15:0] va, input logic [15:0] vb,
                      input int g, input int e, input int l, input int nu, input int lat,
                      input bit tp);
    exp_t x;
    int   waited;
    logic rdy;
    waited = 0;
    @(negedge clk);
    set_in(d, 1'b1, va, vb);
    rdy = get_rdy(d);
    while (!rdy && waited < 50) begin
      @(negedge clk);
      waited++;
      rdy = get_rdy(d);
    end
    if (!rdy) begin
      compared++;
      mismatched++;
      $display("FAIL dut%0d_accept_timeout: got in_ready=0 for 50 cycles, expected 1", d);
    end else begin
      x = '{d, g, e, l, nu, lat, cyc + 1};
      q.push_back(x);
      if (d == 2 && tp) chk("w4_accept_spacing", cyc + 1 - last_acc4, 3);
      if (d == 2) last_acc4 = cyc + 1;
      @(posedge clk);
      #1;
    end
    set_in(d, 1'b0, va, vb);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((q.size() != 0 || ov[0] || ov[1] || ov[2]) && w < 80) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0 || ov[0] || ov[1] || ov[2]) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100us, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    set_in(0, 1'b0, 16'h0, 16'h0);
    set_in(1, 1'b0, 16'h0, 16'h0);
    set_in(2, 1'b0, 16'h0, 16'h0);
    bus_e.out_ready = 1'b1;
    bus_f.out_ready = 1'b1;
    bus_4.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready_e", int'(bus_e.in_ready), 0);
    chk("rst_in_ready_4", int'(bus_4.in_ready), 0);
    chk("rst_out_valid_e", int'(bus_e.out_valid), 0);
    chk("rst_flags_e", {29'd0, bus_e.gt, bus_e.eq, bus_e.lt}, 0);
    chk("rst_nibbles_used_e", onu[0], 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready_e", int'(bus_e.in_ready), 1);
    chk("post_rst_in_ready_f", int'(bus_f.in_ready), 1);

    // 16-bit, early exit
    send(0, 16'h1234, 16'h1234, 0, 1, 0, 4, 4, 1'b0);
    send(0, 16'h8000, 16'h7FFF, 1, 0, 0, 1, 1, 1'b0);
    send(0, 16'h1234, 16'h1235, 0, 0, 1, 4, 4, 1'b0);
    send(0, 16'h0F00, 16'h0E99, 1, 0, 0, 2, 2, 1'b0);
    wait_drain();

    // 16-bit, always full length
    send(1, 16'h8000, 16'h7FFF, 1, 0, 0, 4, 4, 1'b0);
    send(1, 16'h1234, 16'h1234, 0, 1, 0, 4, 4, 1'b0);
    send(1, 16'h0F00, 16'h0E99, 1, 0, 0, 4, 4, 1'b0);
    wait_drain();

    // Backpressure: result held, no accept, stray in_valid ignored
    bus_e.out_ready = 1'b0;
    send(0, 16'hABCD, 16'hABCE, 0, 0, 1, 4, 4, 1'b0);
    w = 0;
    while (!bus_e.out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_in_ready", int'(bus_e.in_ready), 0);
      chk("bp_out_valid", int'(bus_e.out_valid), 1);
      if (i == 3) set_in(0, 1'b1, 16'h0001, 16'h0000);
      else        set_in(0, 1'b0, 16'h0001, 16'h0000);
      @(negedge clk);
    end
    set_in(0, 1'b0, 16'h0, 16'h0);
    bus_e.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", int'(bus_e.in_ready), 1);
    repeat (8) @(negedge clk);
    wait_drain();

    // Reset in the middle of a full-length compare
    @(negedge clk);
    set_in(1, 1'b1, 16'hFFFF, 16'h0000);
    chk("mid_rst_pre_in_ready", int'(bus_f.in_ready), 1);
    @(posedge clk);
    #1;
    set_in(1, 1'b0, 16'hFFFF, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", int'(bus_f.in_ready), 0);
    chk("mid_rst_out_valid", int'(bus_f.out_valid), 0);
    chk("mid_rst_flags", {29'd0, bus_f.gt, bus_f.eq, bus_f.lt}, 0);
    chk("mid_rst_nibbles_used", onu[1], 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_after_in_ready", int'(bus_f.in_ready), 1);
    repeat (8) @(negedge clk);
    send(1, 16'h0001, 16'h0002, 0, 0, 1, 4, 4, 1'b0);
    wait_drain();

    // 4-bit build: single compare cycle, back-to-back every 3 cycles
    send(2, 16'h0009, 16'h000A, 0, 0, 1, 1, 1, 1'b0);
    send(2, 16'h0005, 16'h0005, 0, 1, 0, 1, 1, 1'b1);
    send(2, 16'h000F, 16'h0000, 1, 0, 0, 1, 1, 1'b1);
    send(2, 16'h0000, 16'h000F, 0, 0, 1, 1, 1, 1'b1);
    wait_drain();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

`default_nettype wire
